// File: rtl/red_pitaya_iq_demodulator_block.sv
// IQ demodulator: mixes signal_i with sin/cos and integrates-and-dumps each product over 2^N samples.
// Optional sticky saturation flag on overflow_o is built when IQ_DEMOD_OVERFLOW_FLAG_EN is defined.
module red_pitaya_iq_demodulator_block #(
    parameter int INBITS    = 14,
    parameter int SINBITS   = 14,
    parameter int OUTBITS   = 18,
    parameter int SHIFTBITS = 1,
    parameter int LOG2MAX   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic signed [SINBITS-1:0] sin,
    input  logic signed [SINBITS-1:0] cos,
    input  logic signed [INBITS-1:0]  signal_i,
    input  logic [3:0]                avg_log2_i,
    input  logic                      restart_i,
    output logic signed [OUTBITS-1:0] signal1_o,
    output logic signed [OUTBITS-1:0] signal2_o,
    output logic                      valid_o,
    output logic                      overflow_o
);

    localparam int PW    = INBITS + SINBITS;
    localparam int AW    = PW + LOG2MAX;
    localparam int SHIFT = PW - 1 - OUTBITS - SHIFTBITS;
    localparam int NW    = $clog2(LOG2MAX + 1);
    localparam int CW    = (LOG2MAX > 0) ? LOG2MAX : 1;

    localparam logic signed [AW-1:0] OMAX = AW'((longint'(1) << (OUTBITS - 1)) - 1);
    localparam logic signed [AW-1:0] OMIN = ~OMAX;

    logic signed [INBITS-1:0]  sig_q;
    logic signed [SINBITS-1:0] sin_q;
    logic signed [SINBITS-1:0] cos_q;
    logic                      in_vld;

    logic signed [PW-1:0]      p1;
    logic signed [PW-1:0]      p2;
    logic                      p_vld;

    logic signed [AW-1:0]      acc1;
    logic signed [AW-1:0]      acc2;
    logic [CW-1:0]             cnt;
    logic [NW-1:0]             n_q;
    logic signed [AW-1:0]      avg1;
    logic signed [AW-1:0]      avg2;
    logic                      dump_q;

    logic signed [AW-1:0]      sum1;
    logic signed [AW-1:0]      sum2;
    logic [NW-1:0]             n_new;
    logic                      dump;
    logic signed [AW-1:0]      scaled1;
    logic signed [AW-1:0]      scaled2;
    logic signed [OUTBITS-1:0] sat1;
    logic signed [OUTBITS-1:0] sat2;
    logic                      hit1;
    logic                      hit2;

    // in_vld keeps the reset-time zeros in the input register from being counted as a sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q  <= '0;
            sin_q  <= '0;
            cos_q  <= '0;
            in_vld <= 1'b0;
        end else begin
            sig_q  <= signal_i;
            sin_q  <= sin;
            cos_q  <= cos;
            in_vld <= 1'b1;
        end
    end

    // A restart invalidates the product loaded on that edge, so counting starts with the restart-edge sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p1    <= '0;
            p2    <= '0;
            p_vld <= 1'b0;
        end else begin
            p1    <= sig_q * sin_q;
            p2    <= sig_q * cos_q;
            p_vld <= in_vld & ~restart_i;
        end
    end

    always_comb begin
        sum1  = acc1 + AW'(p1);
        sum2  = acc2 + AW'(p2);
        n_new = (32'(avg_log2_i) > LOG2MAX) ? NW'(LOG2MAX) : NW'(avg_log2_i);
        dump  = p_vld && (cnt == CW'((32'd1 << n_q) - 32'd1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc1   <= '0;
            acc2   <= '0;
            cnt    <= '0;
            n_q    <= '0;
            avg1   <= '0;
            avg2   <= '0;
            dump_q <= 1'b0;
        end else begin
            dump_q <= 1'b0;
            if (restart_i) begin
                acc1 <= '0;
                acc2 <= '0;
                cnt  <= '0;
                n_q  <= n_new;
            end else if (dump) begin
                avg1   <= sum1 >>> n_q;
                avg2   <= sum2 >>> n_q;
                acc1   <= '0;
                acc2   <= '0;
                cnt    <= '0;
                n_q    <= n_new;
                dump_q <= 1'b1;
            end else if (p_vld) begin
                acc1 <= sum1;
                acc2 <= sum2;
                cnt  <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        scaled1 = avg1 >>> SHIFT;
        scaled2 = avg2 >>> SHIFT;
        sat1    = OUTBITS'(scaled1);
        sat2    = OUTBITS'(scaled2);
        hit1    = 1'b0;
        hit2    = 1'b0;
        if (scaled1 > OMAX) begin
            sat1 = OMAX[OUTBITS-1:0];
            hit1 = 1'b1;
        end else if (scaled1 < OMIN) begin
            sat1 = OMIN[OUTBITS-1:0];
            hit1 = 1'b1;
        end
        if (scaled2 > OMAX) begin
            sat2 = OMAX[OUTBITS-1:0];
            hit2 = 1'b1;
        end else if (scaled2 < OMIN) begin
            sat2 = OMIN[OUTBITS-1:0];
            hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            signal1_o <= '0;
            signal2_o <= '0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= dump_q;
            if (dump_q) begin
                signal1_o <= sat1;
                signal2_o <= sat2;
            end
        end
    end

`ifdef IQ_DEMOD_OVERFLOW_FLAG_EN
    // Restart takes priority so a clear is never undone by a result already in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (restart_i) begin
            overflow_o <= 1'b0;
        end else if (dump_q && (hit1 || hit2)) begin
            overflow_o <= 1'b1;
        end
    end
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
// Directed bench for red_pitaya_iq_demodulator_block; expected values are hand-computed.
module tb_red_pitaya_iq_demodulator_block;

`ifdef IQ_DEMOD_OVERFLOW_FLAG_EN
    localparam logic [31:0] OVF = 32'd1;
`else
    localparam logic [31:0] OVF = 32'd0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic signed [13:0] sin;
    logic signed [13:0] cos;
    logic signed [13:0] signal_i;
    logic [3:0]         avg_log2_i;
    logic               restart_i;
    logic signed [17:0] signal1_o;
    logic signed [17:0] signal2_o;
    logic               valid_o;
    logic               overflow_o;

    int vectors = 0;
    int miscompares = 0;
    int cycles;
    int strobes;

    red_pitaya_iq_demodulator_block dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sin        (sin),
        .cos        (cos),
        .signal_i   (signal_i),
        .avg_log2_i (avg_log2_i),
        .restart_i  (restart_i),
        .signal1_o  (signal1_o),
        .signal2_o  (signal2_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_stimulus(input logic signed [13:0] s, input logic signed [13:0] sn,
                                  input logic signed [13:0] cs, input logic [3:0] n, input logic rs);
        signal_i   = s;
        sin        = sn;
        cos        = cs;
        avg_log2_i = n;
        restart_i  = rs;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_o && n < limit);
    endtask

    initial begin
        // Reset state
        apply_stimulus(14'sd1000, 14'sd8191, 14'sd0, 4'd0, 1'b0);
        rst_i = 1'b1;
        repeat (2) tick();
        check_output("rst_sig1", signal1_o, 0);
        check_output("rst_sig2", signal2_o, 0);
        check_output("rst_valid", valid_o, 0);
        check_output("rst_ovf", overflow_o, 0);
        rst_i = 1'b0;

        // N=0: three-cycle latency then a strobe every cycle
        tick(); check_output("n0_lat1", valid_o, 0);
        tick(); check_output("n0_lat2", valid_o, 0);
        tick(); check_output("n0_lat3", valid_o, 0);
        tick();
        check_output("n0_valid", valid_o, 1);
        check_output("n0_sig1", signal1_o, 31996);
        check_output("n0_sig2", signal2_o, 0);
        tick(); check_output("n0_valid_next", valid_o, 1);

        // N=4 window of 16 constant samples
        apply_stimulus(-14'sd2000, 14'sd4096, -14'sd4096, 4'd4, 1'b1);
        tick();
        restart_i = 1'b0;
        strobes = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (valid_o) strobes++;
        end
        check_output("n4_no_early", strobes, 0);
        tick();
        check_output("n4_valid", valid_o, 1);
        check_output("n4_sig1", signal1_o, -32000);
        check_output("n4_sig2", signal2_o, 32000);
        wait_strobe(40, cycles);
        check_output("n4_period", cycles, 16);

        // Saturation at both rails, then restart clears the flag
        apply_stimulus(-14'sd8192, -14'sd8192, 14'sd8191, 4'd0, 1'b1);
        tick();
        restart_i = 1'b0;
        tick(); tick(); tick();
        check_output("sat_valid", valid_o, 1);
        check_output("sat_sig1", signal1_o, 131071);
        check_output("sat_sig2", signal2_o, -131072);
        check_output("sat_ovf", overflow_o, OVF);
        tick();
        check_output("sat_ovf_sticky", overflow_o, OVF);
        apply_stimulus(14'sd1000, 14'sd8191, 14'sd0, 4'd0, 1'b1);
        tick();
        restart_i = 1'b0;
        check_output("clr_ovf", overflow_o, 0);
        check_output("clr_sig1_hold", signal1_o, 131071);
        tick(); tick(); tick();
        check_output("clr_sig1", signal1_o, 31996);
        check_output("clr_ovf_after", overflow_o, 0);

        // N=3, restart on the 5th sample; result averages only post-restart samples
        apply_stimulus(14'sd1000, 14'sd8191, 14'sd0, 4'd3, 1'b1);
        tick();
        restart_i = 1'b0;
        repeat (3) tick();
        apply_stimulus(14'sd100, 14'sd4096, -14'sd4096, 4'd3, 1'b1);
        tick();
        restart_i = 1'b0;
        strobes = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 7) signal_i = 14'(100 * (k + 1));
            tick();
            if (valid_o) strobes++;
        end
        check_output("rs_no_partial", strobes, 0);
        tick();
        check_output("rs_valid", valid_o, 1);
        check_output("rs_sig1", signal1_o, 7200);
        check_output("rs_sig2", signal2_o, -7200);

        // Requested N=15 clamps to 10
        apply_stimulus(14'sd1000, 14'sd8191, 14'sd0, 4'd15, 1'b1);
        tick();
        restart_i = 1'b0;
        wait_strobe(1100, cycles);
        check_output("clamp_first", cycles, 1026);
        check_output("clamp_sig1", signal1_o, 31996);
        check_output("clamp_sig2", signal2_o, 0);
        wait_strobe(1100, cycles);
        check_output("clamp_period", cycles, 1024);

        // Asynchronous reset mid-window, then power-up behaviour with N=0
        repeat (300) tick();
        rst_i = 1'b1;
        #1;
        check_output("arst_sig1", signal1_o, 0);
        check_output("arst_sig2", signal2_o, 0);
        check_output("arst_valid", valid_o, 0);
        check_output("arst_ovf", overflow_o, 0);
        apply_stimulus(14'sd1000, 14'sd8191, 14'sd0, 4'd0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick(); tick(); tick();
        check_output("rel_lat", valid_o, 0);
        tick();
        check_output("rel_valid", valid_o, 1);
        check_output("rel_sig1", signal1_o, 31996);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
